// File: rtl/axi_cache_bridge_if.sv
// AXI4 master bus used by the cache bridge.
// Carries the five AXI channels: AR, R, AW, W and B.
//   master : the bridge side. It drives the address and write channels plus rready and bready.
//   slave  : the interconnect or memory side. It drives the ready signals, the R channel and the B channel.
interface axi_cache_bridge_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_cache_bridge.sv
// Bridge from the cache request/return interface to an AXI4 master.
// It allows one outstanding read and one outstanding write at a time.
//
// Ports:
//   clk, resetn                        clock and synchronous active-low reset
//   rd_req/rd_type/rd_addr, rd_rdy     read request, accepted on rd_req & rd_rdy
//   ret_valid/ret_last/ret_data        read beats passed straight through from the R channel
//   wr_req/wr_type/wr_addr/wr_wstrb    write request, accepted on wr_req & wr_rdy
//   wr_data, wr_rdy                    write line data (word 0 is bits [31:0]), write ready
//   axi                                AXI4 master bus (AR/R/AW/W/B)
//
// Request types: 000 byte, 001 half, 010 word, 100 full line (INCR burst).
module axi_cache_bridge #(
  parameter int LINE_WIDTH   = 256,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_req,
  input  logic [2:0]            rd_type,
  input  logic [31:0]           rd_addr,
  output logic                  rd_rdy,
  output logic                  ret_valid,
  output logic                  ret_last,
  output logic [31:0]           ret_data,
  input  logic                  wr_req,
  input  logic [2:0]            wr_type,
  input  logic [31:0]           wr_addr,
  input  logic [3:0]            wr_wstrb,
  input  logic [LINE_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  axi_cache_bridge_if.master    axi
);

  localparam int          NBEATS   = LINE_WIDTH / 32;
  localparam logic [7:0]  LINE_LEN = 8'(NBEATS - 1);
  localparam logic [2:0]  T_LINE   = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA}      r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_t;

  function automatic logic [7:0] len_of(input logic [2:0] t);
    return (t == T_LINE) ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [31:0]           rd_addr_q;
  logic [2:0]            rd_type_q;
  logic [31:0]           wr_addr_q;
  logic [2:0]            wr_type_q;
  logic [3:0]            wr_wstrb_q;
  logic [LINE_WIDTH-1:0] wbuf;
  logic [7:0]            beat_cnt;
  logic [7:0]            aw_len;
  logic                  same_line;
  logic                  rd_accept;
  logic                  wr_accept;

  // The response ID and response code are consumed but have no effect.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  assign aw_len    = len_of(wr_type_q);
  // Compare only the line-address bits of the two requests.
  assign same_line = rd_addr[31:OFFSET_WIDTH] == wr_addr_q[31:OFFSET_WIDTH];
  assign rd_accept = rd_req & rd_rdy;
  assign wr_accept = wr_req & wr_rdy;

  // Address and write fields come from the request registers. They are valid while arvalid/awvalid is high.
  assign axi.arid    = 4'd0;
  assign axi.araddr  = rd_addr_q;
  assign axi.arlen   = len_of(rd_type_q);
  assign axi.arsize  = size_of(rd_type_q);
  assign axi.arburst = 2'b01;
  assign axi.awid    = 4'd1;
  assign axi.awaddr  = wr_addr_q;
  assign axi.awlen   = aw_len;
  assign axi.awsize  = size_of(wr_type_q);
  assign axi.awburst = 2'b01;
  assign axi.wdata   = wbuf[31:0];
  assign axi.wstrb   = (wr_type_q == T_LINE) ? 4'hF : wr_wstrb_q;

  // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Read FSM: next state and outputs.
  // NOTE: every output gets a default at the top, so no path through the case can infer a latch.
  always_comb begin
    r_next      = r_state;
    rd_rdy      = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    ret_valid   = 1'b0;
    ret_last    = 1'b0;
    ret_data    = 32'd0;
    unique case (r_state)
      R_IDLE: begin
        // A read must not pass a pending write to the same line.
        rd_rdy = (w_state == W_IDLE) || !same_line;
        if (rd_req && rd_rdy) r_next = R_AR;
      end
      R_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) r_next = R_DATA;
      end
      R_DATA: begin
        // The cache always accepts a beat, so rready depends only on the state.
        axi.rready = 1'b1;
        ret_valid  = axi.rvalid;
        ret_data   = axi.rdata;
        ret_last   = axi.rvalid & axi.rlast;
        if (axi.rvalid && axi.rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM: next state and outputs.
  always_comb begin
    w_next      = w_state;
    wr_rdy      = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) w_next = W_AW;
      end
      W_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) w_next = W_DATA;
      end
      W_DATA: begin
        axi.wvalid = 1'b1;
        axi.wlast  = (beat_cnt == aw_len);
        if (axi.wready && axi.wlast) w_next = W_B;
      end
      W_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Request registers and the write beat counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_addr_q  <= 32'd0;
      rd_type_q  <= 3'd0;
      wr_addr_q  <= 32'd0;
      wr_type_q  <= 3'd0;
      wr_wstrb_q <= 4'd0;
      beat_cnt   <= 8'd0;
    end else begin
      if (rd_accept) begin
        rd_addr_q <= rd_addr;
        rd_type_q <= rd_type;
      end
      if (wr_accept) begin
        wr_addr_q  <= wr_addr;
        wr_type_q  <= wr_type;
        wr_wstrb_q <= wr_wstrb;
        beat_cnt   <= 8'd0;
      end else if (w_state == W_DATA && axi.wready) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Write line shift register. The current beat is always in bits [31:0].
  // NOTE: this wide data register has no reset. It is always loaded on acceptance before it is read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wbuf <= wr_data;
    end else if (w_state == W_DATA && axi.wready) begin
      wbuf <= wbuf >> 32;
    end
  end

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Self-checking bench for axi_cache_bridge.
// The bench acts as the AXI slave and the cache. Expected values come from the
// request-type rules: line is an N-beat burst of size 2; word, half and byte are
// single beats of size 2, 1 and 0. Write beats are the words of wr_data, taken in order.
module tb_axi_cache_bridge;
  localparam int LW = 256;
  localparam int N  = LW / 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          rd_req;
  logic [2:0]    rd_type;
  logic [31:0]   rd_addr;
  logic          rd_rdy;
  logic          ret_valid;
  logic          ret_last;
  logic [31:0]   ret_data;
  logic          wr_req;
  logic [2:0]    wr_type;
  logic [31:0]   wr_addr;
  logic [3:0]    wr_wstrb;
  logic [LW-1:0] wr_data;
  logic          wr_rdy;

  int errors = 0;
  int checks = 0;

  axi_cache_bridge_if axi();

  axi_cache_bridge #(.LINE_WIDTH(LW), .OFFSET_WIDTH(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .axi       (axi.master)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rdata = 0; axi.rresp = 0; axi.rid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
  endtask

  function automatic logic [9:0] idle_vec();
    return {axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, axi.rready,
            axi.bready, ret_valid, ret_last, rd_rdy, wr_rdy};
  endfunction

  // Full read transaction with the AR delay and R-stall percentage given by the caller.
  task automatic run_read(input logic [2:0] typ, input logic [31:0] addr, input int ar_delay,
                          input int stall_pct, input bit seq_data, input string tag);
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [31:0] d;
    int          beats;
    int          b;
    int          cyc;
    bit          stall;
    exp_len  = (typ == 3'b100) ? 8'(N - 1) : 8'd0;
    exp_size = (typ == 3'b100) ? 3'd2 : typ;
    beats    = int'(exp_len) + 1;
    rd_req = 1; rd_type = typ; rd_addr = addr;
    #1;
    checks++;
    if (rd_rdy !== 1'b1 || axi.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: rd_rdy=%b arvalid=%b, expected 1/0", tag, rd_rdy, axi.arvalid);
    end
    tick;
    rd_req = 0; rd_addr = $urandom; rd_type = 3'($urandom);
    for (int k = 0; k <= ar_delay; k++) begin
      axi.arready = (k == ar_delay);
      #1;
      checks++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== addr || axi.arlen !== exp_len ||
          axi.arsize !== exp_size || axi.arburst !== 2'b01 || axi.arid !== 4'd0 || axi.rready !== 1'b0) begin
        errors++;
        $display("FAIL %s ar[%0d]: arvalid=%b addr=%h len=%0d size=%0d burst=%b id=%0d rready=%b, expected 1 %h %0d %0d 01 0 0",
                 tag, k, axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, axi.rready,
                 addr, exp_len, exp_size);
      end
      tick;
    end
    axi.arready = 0;
    b = 0; cyc = 0;
    while (b < beats && cyc < 300) begin
      stall = ($urandom_range(0, 99) < stall_pct);
      d = seq_data ? 32'(b) : $urandom;
      axi.rvalid = !stall; axi.rdata = d; axi.rlast = !stall && (b == beats - 1);
      #1;
      checks++;
      if (stall) begin
        if (ret_valid !== 1'b0 || ret_last !== 1'b0 || axi.rready !== 1'b1) begin
          errors++;
          $display("FAIL %s stall: ret_valid=%b ret_last=%b rready=%b, expected 0 0 1",
                   tag, ret_valid, ret_last, axi.rready);
        end
      end else if (ret_valid !== 1'b1 || ret_data !== d || ret_last !== 1'(b == beats - 1) ||
                   axi.rready !== 1'b1 || axi.arvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s beat%0d: valid=%b data=%h last=%b rready=%b arvalid=%b, expected 1 %h %b 1 0",
                 tag, b, ret_valid, ret_data, ret_last, axi.rready, axi.arvalid, d, 1'(b == beats - 1));
      end
      tick;
      if (!stall) b++;
      cyc++;
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    checks++;
    if (b < beats || rd_rdy !== 1'b1 || axi.rready !== 1'b0 || ret_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end: beats=%0d rd_rdy=%b rready=%b ret_valid=%b, expected %0d 1 0 0",
               tag, b, rd_rdy, axi.rready, ret_valid, beats);
    end
  endtask

  // Full write transaction. wmode selects how wready behaves: 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_write(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [LW-1:0] data, input int aw_delay, input int wmode,
                           input int b_delay, input string tag);
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
    logic [31:0] exp_word;
    int          beats;
    int          b;
    int          cyc;
    exp_len  = (typ == 3'b100) ? 8'(N - 1) : 8'd0;
    exp_size = (typ == 3'b100) ? 3'd2 : typ;
    exp_strb = (typ == 3'b100) ? 4'hF : strb;
    beats    = int'(exp_len) + 1;
    wr_req = 1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
    #1;
    checks++;
    if (wr_rdy !== 1'b1 || axi.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: wr_rdy=%b awvalid=%b, expected 1/0", tag, wr_rdy, axi.awvalid);
    end
    tick;
    wr_req = 0; wr_addr = $urandom; wr_wstrb = 4'($urandom); wr_data = '0; wr_type = 3'($urandom);
    for (int k = 0; k <= aw_delay; k++) begin
      axi.awready = (k == aw_delay);
      #1;
      checks++;
      if (axi.awvalid !== 1'b1 || axi.awaddr !== addr || axi.awlen !== exp_len || axi.awsize !== exp_size ||
          axi.awburst !== 2'b01 || axi.awid !== 4'd1 || axi.wvalid !== 1'b0 || wr_rdy !== 1'b0) begin
        errors++;
        $display("FAIL %s aw[%0d]: awvalid=%b addr=%h len=%0d size=%0d burst=%b id=%0d wvalid=%b wr_rdy=%b, expected 1 %h %0d %0d 01 1 0 0",
                 tag, k, axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid, axi.wvalid,
                 wr_rdy, addr, exp_len, exp_size);
      end
      tick;
    end
    axi.awready = 0;
    b = 0; cyc = 0;
    while (b < beats && cyc < 300) begin
      case (wmode)
        0:       axi.wready = 1;
        1:       axi.wready = (cyc % 2 == 1);
        default: axi.wready = 1'($urandom_range(0, 1));
      endcase
      exp_word = data[32*b +: 32];
      #1;
      checks++;
      if (axi.wvalid !== 1'b1 || axi.wdata !== exp_word || axi.wstrb !== exp_strb ||
          axi.wlast !== 1'(b == beats - 1) || axi.awvalid !== 1'b0 || axi.bready !== 1'b0) begin
        errors++;
        $display("FAIL %s w%0d: wvalid=%b wdata=%h wstrb=%h wlast=%b awvalid=%b bready=%b, expected 1 %h %h %b 0 0",
                 tag, b, axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, axi.awvalid, axi.bready,
                 exp_word, exp_strb, 1'(b == beats - 1));
      end
      tick;
      if (axi.wready) b++;
      cyc++;
    end
    axi.wready = 0;
    for (int k = 0; k <= b_delay; k++) begin
      axi.bvalid = (k == b_delay);
      #1;
      checks++;
      if (axi.bready !== 1'b1 || axi.wvalid !== 1'b0 || axi.wlast !== 1'b0 || wr_rdy !== 1'b0) begin
        errors++;
        $display("FAIL %s b[%0d]: bready=%b wvalid=%b wlast=%b wr_rdy=%b, expected 1 0 0 0",
                 tag, k, axi.bready, axi.wvalid, axi.wlast, wr_rdy);
      end
      tick;
    end
    axi.bvalid = 0;
    #1;
    checks++;
    if (b < beats || wr_rdy !== 1'b1 || axi.bready !== 1'b0) begin
      errors++;
      $display("FAIL %s end: beats=%0d wr_rdy=%b bready=%b, expected %0d 1 0", tag, b, wr_rdy, axi.bready, beats);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 0;
    tick;
    tick;
    checks++;
    if (idle_vec() !== 10'b0000000011) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected 0000000011", idle_vec());
    end
    resetn = 1;
    #1;
    checks++;
    if (idle_vec() !== 10'b0000000011) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 0000000011", idle_vec());
    end
  endtask

  task automatic test_line_read;
    run_read(3'b100, 32'h1C00_0040, 0, 0, 1, "line_read");
  endtask

  task automatic test_word_read;
    run_read(3'b010, 32'hBFAF_8000, 3, 0, 0, "word_read");
  endtask

  task automatic test_line_write;
    logic [LW-1:0] d;
    for (int k = 0; k < N; k++) d[32*k +: 32] = 32'h80 + 32'(k);
    run_write(3'b100, 32'h0000_1000, 4'h0, d, 0, 1, 2, "line_write");
  endtask

  task automatic test_byte_write;
    logic [LW-1:0] d;
    for (int k = 0; k < N; k++) d[32*k +: 32] = $urandom;
    d[31:0] = 32'h00AB_0000;
    run_write(3'b000, 32'h0000_4002, 4'b0100, d, 1, 0, 0, "byte_write");
  endtask

  task automatic test_hazard;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h2000; wr_data = {N{32'h1234_5678}};
    #1;
    tick;
    wr_req = 0;
    axi.awready = 1;
    #1;
    tick;
    axi.awready = 0; axi.wready = 0;
    rd_req = 1; rd_type = 3'b010; rd_addr = 32'h2010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rd_rdy !== 1'b0 || axi.wvalid !== 1'b1) begin
        errors++;
        $display("FAIL hazard_block[%0d]: rd_rdy=%b wvalid=%b, expected 0 1", k, rd_rdy, axi.wvalid);
      end
      tick;
    end
    rd_addr = 32'h3000;
    #1;
    checks++;
    if (rd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_other_line: rd_rdy=%b expected 1", rd_rdy);
    end
    tick;
    rd_req = 0;
    axi.arready = 1;
    #1;
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h3000 || axi.wvalid !== 1'b1) begin
      errors++;
      $display("FAIL hazard_ar: arvalid=%b araddr=%h wvalid=%b, expected 1 00003000 1",
               axi.arvalid, axi.araddr, axi.wvalid);
    end
    tick;
    axi.arready = 0;
    axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'h5A5A_0001;
    #1;
    checks++;
    if (ret_valid !== 1'b1 || ret_last !== 1'b1 || ret_data !== 32'h5A5A_0001) begin
      errors++;
      $display("FAIL hazard_ret: valid=%b last=%b data=%h, expected 1 1 5a5a0001", ret_valid, ret_last, ret_data);
    end
    tick;
    axi.rvalid = 0; axi.rlast = 0;
    rd_req = 1; rd_addr = 32'h2010;
    axi.wready = 1;
    for (int k = 0; k < N; k++) begin
      #1;
      checks++;
      if (rd_rdy !== 1'b0 || axi.wvalid !== 1'b1) begin
        errors++;
        $display("FAIL hazard_wdata[%0d]: rd_rdy=%b wvalid=%b, expected 0 1", k, rd_rdy, axi.wvalid);
      end
      tick;
    end
    axi.wready = 0;
    axi.bvalid = 1;
    #1;
    checks++;
    if (rd_rdy !== 1'b0 || axi.bready !== 1'b1) begin
      errors++;
      $display("FAIL hazard_wb: rd_rdy=%b bready=%b, expected 0 1", rd_rdy, axi.bready);
    end
    tick;
    axi.bvalid = 0;
    #1;
    checks++;
    if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_release: rd_rdy=%b wr_rdy=%b, expected 1 1", rd_rdy, wr_rdy);
    end
    tick;
    rd_req = 0;
    axi.arready = 1;
    #1;
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h2010) begin
      errors++;
      $display("FAIL hazard_ar2: arvalid=%b araddr=%h, expected 1 00002010", axi.arvalid, axi.araddr);
    end
    tick;
    axi.arready = 0;
    axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'hCAFE_0002;
    #1;
    tick;
    axi.rvalid = 0; axi.rlast = 0;
    #1;
    checks++;
    if (rd_rdy !== 1'b1 || axi.rready !== 1'b0) begin
      errors++;
      $display("FAIL hazard_done: rd_rdy=%b rready=%b, expected 1 0", rd_rdy, axi.rready);
    end
  endtask

  task automatic test_reset_mid_read;
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1C00_0080;
    #1;
    tick;
    rd_req = 0;
    axi.arready = 1;
    #1;
    tick;
    axi.arready = 0;
    for (int k = 0; k < 3; k++) begin
      axi.rvalid = 1; axi.rlast = 0; axi.rdata = 32'(k);
      #1;
      tick;
    end
    axi.rdata = 32'd3;
    resetn = 0;
    #1;
    tick;
    resetn = 1;
    axi.rvalid = 0;
    #1;
    checks++;
    if (idle_vec() !== 10'b0000000011) begin
      errors++;
      $display("FAIL reset_mid_read: outputs=%b expected 0000000011", idle_vec());
    end
    run_read(3'b100, 32'h1C00_00C0, 0, 0, 1, "post_reset_read");
  endtask

  task automatic test_back_to_back;
    logic [LW-1:0] d;
    for (int k = 0; k < N; k++) d[32*k +: 32] = $urandom;
    run_read(3'b010, 32'h0000_0100, 0, 0, 0, "b2b_rd0");
    run_read(3'b100, 32'h0000_0200, 0, 0, 0, "b2b_rd1");
    run_write(3'b100, 32'h0000_0300, 4'h0, d, 0, 0, 0, "b2b_wr0");
    run_write(3'b001, 32'h0000_0402, 4'b1100, d, 0, 0, 0, "b2b_wr1");
  endtask

  task automatic test_random;
    logic [2:0]    types [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [2:0]    typ;
    logic [LW-1:0] d;
    for (int i = 0; i < 24; i++) begin
      typ = types[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        run_read(typ, $urandom, $urandom_range(0, 3), 30, 0, "rand_rd");
      end else begin
        for (int k = 0; k < N; k++) d[32*k +: 32] = $urandom;
        run_write(typ, $urandom, 4'($urandom), d, $urandom_range(0, 3), 2, $urandom_range(0, 3), "rand_wr");
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_read();
    test_word_read();
    test_line_write();
    test_byte_write();
    test_hazard();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
